// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared FSM encodings and address-map constants for mem_responder
package mem_map_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {K_RAM, K_LED, K_CNT, K_NONE} kind_t;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h4000_0000;
    localparam logic [31:0] LED_OFF   = 32'h0000_0000;
    localparam logic [31:0] CNT_OFF   = 32'h0000_0004;
endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port synchronous word RAM with write enable and registered read
module mem_responder_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);
    logic [31:0] mem [DEPTH_WORDS];
    // contents are deliberately not reset; q only moves on an explicit read
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) q <= mem[idx];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated memory responder; MMIO window (LED, cycle counter) under MEM_RESPONDER_MMIO_EN
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err,
    output logic [7:0]  led
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LED_ADDR = MMIO_BASE + LED_OFF;
    localparam logic [31:0] CNT_ADDR = MMIO_BASE + CNT_OFF;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wd_q;
    logic          wr_q, err_q;
    kind_t         kind_q;
    logic          rd_sel;
    logic [31:0]   rd_oth;
    logic [31:0]   ram_q;
    logic [31:0]   mm_val;

    logic          req, ram_hit, led_hit, cnt_hit, d_err, last;
    logic          c_err, c_wr, ram_re, ram_we;
    kind_t         d_kind, c_kind;
    logic [31:0]   rel;
    logic [AW-1:0] c_idx;

    // decode the live request; c_* is the request being served (live in IDLE, latched otherwise)
    always_comb begin
        req     = mem_read | mem_write;
        rel     = addr - RAM_BASE;
        ram_hit = (rel >> (AW + 2)) == 32'd0;
`ifdef MEM_RESPONDER_MMIO_EN
        led_hit = {addr[31:2], 2'b00} == LED_ADDR;
        cnt_hit = {addr[31:2], 2'b00} == CNT_ADDR;
`else
        led_hit = 1'b0;
        cnt_hit = 1'b0;
`endif
        d_kind  = ram_hit ? K_RAM : led_hit ? K_LED : cnt_hit ? K_CNT : K_NONE;
        d_err   = (addr[1:0] != 2'b00) | (mem_read & mem_write) | (d_kind == K_NONE)
                | (mem_write & (d_kind == K_CNT));
        c_err   = (state == S_IDLE) ? d_err : err_q;
        c_wr    = (state == S_IDLE) ? mem_write : wr_q;
        c_kind  = (state == S_IDLE) ? d_kind : kind_q;
        c_idx   = (state == S_IDLE) ? rel[AW+1:2] : idx_q;
        last    = (state == S_IDLE) ? (req && WAIT_CYCLES == 0) : (state == S_WAIT && cnt == 4'd1);
        ram_re  = last & ~c_err & ~c_wr & (c_kind == K_RAM);
        ram_we  = (state == S_RESP) & wr_q & ~err_q & (kind_q == K_RAM);
        rdata   = rd_sel ? ram_q : rd_oth;
    end

    mem_responder_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (c_idx),
        .wdata (wd_q),
        .q     (ram_q)
    );

`ifdef MEM_RESPONDER_MMIO_EN
    logic [31:0] cyc;
    // free-running cycle counter and LED register; LED commits on the edge leaving RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc <= '0;
            led <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (state == S_RESP && wr_q && !err_q && kind_q == K_LED) led <= wd_q[7:0];
        end
    end
    assign mm_val = (c_kind == K_LED) ? {24'd0, led} : cyc;
`else
    assign led    = '0;
    assign mm_val = '0;
`endif

    // request FSM with registered ready/addr_err and read-data select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            wd_q     <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            kind_q   <= K_RAM;
            ready    <= 1'b0;
            addr_err <= 1'b0;
            rd_sel   <= 1'b0;
            rd_oth   <= '0;
        end else begin
            ready    <= last;
            addr_err <= last & c_err;
            if (last && (c_err || !c_wr)) begin
                rd_sel <= ~c_err & (c_kind == K_RAM);
                rd_oth <= c_err ? 32'd0 : mm_val;
            end
            case (state)
                S_IDLE: if (req) begin
                    idx_q  <= rel[AW+1:2];
                    wd_q   <= wdata;
                    wr_q   <= mem_write;
                    err_q  <= d_err;
                    kind_q <= d_kind;
                    cnt    <= 4'(WAIT_CYCLES);
                    state  <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (WAIT_CYCLES=1 and 0 instances)
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
    logic [31:0] q0, q1;
    logic        rdy0, rdy1, err0, err1;
    logic [7:0]  led0, led1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .addr(a0), .wdata(d0),
        .rdata(q0), .ready(rdy0), .addr_err(err0), .led(led0)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .addr(a1), .wdata(d1),
        .rdata(q1), .ready(rdy1), .addr_err(err1), .led(led1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one request on u0 at a negedge; lat counts negedges until ready (0 = timed out)
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic hold, output logic [31:0] q, output logic e, output int lat);
        rd0 = r; wr0 = w; a0 = a; d0 = d;
        lat = 0; q = '0; e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!hold) begin rd0 = 1'b0; wr0 = 1'b0; end
            if (rdy0) begin lat = i; q = q0; e = err0; break; end
        end
        rd0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, c1, c2;
        logic        e, saw;
        int          lat, pulses;
        repeat (3) @(negedge clk);
        check("rst ready", {31'd0, rdy0}, 32'd0);
        check("rst addr_err", {31'd0, err0}, 32'd0);
        check("rst rdata", q0, 32'd0);
        check("rst led", {24'd0, led0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post-rst ready", {31'd0, rdy0}, 32'd0);

        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, q, e, lat);
        check("wr10 latency", lat, 2);
        check("wr10 err", {31'd0, e}, 32'd0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, q, e, lat);
        check("rd10 latency", lat, 2);
        check("rd10 data", q, 32'hDEAD_BEEF);
        check("rd10 err", {31'd0, e}, 32'd0);

        access(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, q, e, lat);
        check("rd13 err", {31'd0, e}, 32'd1);
        check("rd13 data", q, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, q, e, lat);
        check("rd10 dropped-strobe latency", lat, 2);
        check("rd10 again", q, 32'hDEAD_BEEF);

        access(1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b1, q, e, lat);
        access(1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b1, q, e, lat);
        check("rw20 err", {31'd0, e}, 32'd1);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, q, e, lat);
        check("rd20 unmodified", q, 32'h1111_1111);

        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, q, e, lat);
        check("rd400 out of range", {31'd0, e}, 32'd1);
        access(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b1, q, e, lat);
        check("upper bit err", {31'd0, e}, 32'd1);
        access(1'b0, 1'b1, 32'h3FC, 32'hA5A5_5A5A, 1'b1, q, e, lat);
        check("wr3fc err", {31'd0, e}, 32'd0);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1, q, e, lat);
        check("rd3fc data", q, 32'hA5A5_5A5A);

`ifdef MEM_RESPONDER_MMIO_EN
        access(1'b0, 1'b1, 32'h4000_0000, 32'h0000_01A5, 1'b1, q, e, lat);
        check("led wr err", {31'd0, e}, 32'd0);
        check("led value", {24'd0, led0}, 32'hA5);
        access(1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b1, q, e, lat);
        check("led readback", q, 32'h0000_00A5);
        access(1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b1, c1, e, lat);
        repeat (7) @(negedge clk);
        access(1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b1, c2, e, lat);
        check("cycle delta", c2 - c1, 32'd10);
        access(1'b0, 1'b1, 32'h4000_0004, 32'h5, 1'b1, q, e, lat);
        check("cnt write err", {31'd0, e}, 32'd1);
`else
        access(1'b0, 1'b1, 32'h4000_0000, 32'h0000_01A5, 1'b1, q, e, lat);
        check("led wr err (no mmio)", {31'd0, e}, 32'd1);
        check("led tied 0", {24'd0, led0}, 32'h0);
        access(1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b1, q, e, lat);
        check("cnt rd err (no mmio)", {31'd0, e}, 32'd1);
        check("cnt rd data (no mmio)", q, 32'h0);
`endif

        access(1'b0, 1'b1, 32'h30, 32'h1234_5678, 1'b1, q, e, lat);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, q, e, lat);
        wr0 = 1'b1; a0 = 32'h30; d0 = 32'h0000_0099;
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | rdy0;
        end
        check("abort no ready", {31'd0, saw}, 32'd0);
        check("abort rdata", q0, 32'h0);
        check("abort addr_err", {31'd0, err0}, 32'd0);
        check("abort led", {24'd0, led0}, 32'h0);
        wr0 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, q, e, lat);
        check("rd30 kept", q, 32'h1234_5678);

        wr1 = 1'b1; a1 = 32'h8; d1 = 32'hCAFE_F00D;
        @(negedge clk);
        check("w0 write ready", {31'd0, rdy1}, 32'd1);
        wr1 = 1'b0;
        @(negedge clk);
        check("w0 idle gap", {31'd0, rdy1}, 32'd0);
        rd1 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("w0 ready pattern %0d", i), {31'd0, rdy1}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (rdy1) begin
                pulses++;
                check($sformatf("w0 rdata %0d", i), q1, 32'hCAFE_F00D);
            end
        end
        rd1 = 1'b0;
        check("w0 pulse count", pulses, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle CPU's memory interface. It serves instruction-fetch, load and store requests issued by the controller's `MemRead`/`MemWrite` strobes, using a word-addressed data RAM with a configurable wait-state count. It signals completion with a one-cycle `ready` pulse and flags illegal accesses on `addr_err`; the controller feeds that flag into its exception path. An optional MMIO window exposes an LED register and a free-running cycle counter.

## Interface
- `DEPTH_WORDS`, 256: RAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states inserted between accept and response; range 0–15.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request level.
- `mem_write` input 1: write request level.
- `addr` input 32: byte address; must be word-aligned.
- `wdata` input 32: store data.
- `rdata` output 32: read data; registered.
- `ready` output 1: one-cycle completion pulse.
- `addr_err` output 1: error qualifier; valid only while `ready` is high.
- `led` output 8: MMIO LED register (drives 0 when MMIO is compiled out).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, with `mem_read` or `mem_write` high:
  - Latch `addr`, `wdata` and the operation type.
  - Load the wait counter with `WAIT_CYCLES`.
  - Next state is WAIT, or RESP when `WAIT_CYCLES`=0.
- WAIT: decrement the counter; go to RESP when counter==1. Request inputs are ignored.
- RESP:
  - `ready`=1.
  - Reads: `rdata` updates on the edge entering RESP and holds until the next RESP.
  - Writes: commit on the edge leaving RESP.
  - Next state is always IDLE. A request still high in IDLE is a new request; the requester must drop its strobe in the cycle `ready` is seen.
- Error decode, computed at accept on the latched request. An error sets `addr_err`=1 in RESP, suppresses the write, and forces `rdata`=0:
  - `addr[1:0]`≠0.
  - Word index ≥ `DEPTH_WORDS` outside the MMIO window.
  - `mem_read` and `mem_write` high in the same cycle.
  - Write to a read-only MMIO register.
- RAM index = `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits must be zero for a RAM hit.
- MMIO window (`MEM_RESPONDER_MMIO_EN` only):
  - `0x4000_0000`: LED register, R/W, low 8 bits; upper 24 bits read 0 and are ignored on write.
  - `0x4000_0004`: cycle counter, read-only, 32-bit, +1 every clock, wraps at 2^32−1 → 0.

## Timing
- Request sampled in IDLE at cycle 0 → `ready` high in cycle 1+`WAIT_CYCLES`.
- Back-to-back throughput: one access per 2+`WAIT_CYCLES` cycles.
- Reset values: state IDLE, `ready`=0, `addr_err`=0, `rdata`=0, `led`=0, cycle counter=0.
- RAM contents are not reset.
- Reset asserted in WAIT or RESP aborts the access: no write commits, no `ready` pulse.
- Deasserting the request during WAIT does not cancel it; the response still issues.

## Configuration
- `MEM_RESPONDER_MMIO_EN` defined: MMIO window decoded, LED register and cycle counter instantiated.
- Not defined: no MMIO logic; addresses `0x4000_0000`/`0x4000_0004` decode as out-of-range and set `addr_err`; `led` is tied to 0.

## Structure
- Shared package `mem_map_pkg`: FSM state encodings, MMIO base and offset constants, RAM base address.
- Sub-module `mem_responder_ram`: single-port synchronous RAM with write enable and registered read. Depth comes from `DEPTH_WORDS`.
- FSM, error decode and MMIO registers live in the top module.

## Test plan
- `WAIT_CYCLES`=1: write `0xDEADBEEF` to `0x10`, then read `0x10` → each `ready` arrives 2 cycles after the request; read `rdata`=`0xDEADBEEF`, `addr_err`=0.
- Read `0x13` (misaligned) → `ready` with `addr_err`=1, `rdata`=0. A following read of `0x10` returns the old value unchanged.
- `mem_read` and `mem_write` high together at `0x20` → `addr_err`=1. Word `0x20` is unmodified.
- MMIO enabled:
  - Write `0x1A5` to `0x4000_0000` → `led`=`0xA5`.
  - Read `0x4000_0004` twice, 10 cycles apart → values differ by 10.
  - Write to `0x4000_0004` → `addr_err`=1.
- Assert `reset` low during WAIT of a write to `0x30` → no `ready` pulse; `0x30` keeps its prior contents; all outputs return to reset values.
- `WAIT_CYCLES`=0, read request held high continuously → `ready` pulses every 2nd cycle, each pulse a separate completed access.
